// File: rtl/sass_pkg.sv
// sass_pkg: shared SASS line constants and receiver state encoding
//   SASS_FRAME_L : default data bits per frame
//   SASS_T       : default clock cycles per bit
package sass_pkg;
    localparam int SASS_FRAME_L = 8;
    localparam int SASS_T = 100;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} sass_state_e;
endpackage

// File: rtl/sass_r_if.sv
// sass_r_if: serial line in, received frame out
//   s     : serial line (driven by master, asynchronous to clk)
//   data  : last correctly received frame
//   valid : one-cycle pulse when data updates
//   busy  : high while a frame is being received
//   err   : one-cycle pulse on framing error
interface sass_r_if import sass_pkg::*; #(parameter int frame_l = SASS_FRAME_L) ();
    logic s;
    logic [frame_l-1:0] data;
    logic valid;
    logic busy;
    logic err;
    modport master (output s, input data, valid, busy, err);
    modport slave (input s, output data, valid, busy, err);
endinterface

// File: rtl/sass_bit_timer.sv
// sass_bit_timer: per-bit cycle counter 0..t-1
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : hold the counter at 0
//   mid_o    : counter at the decision point mid_at
//   end_o    : counter at t-1 (last cycle of the bit)
module sass_bit_timer import sass_pkg::*; #(
    parameter int t = SASS_T,
    parameter int mid_at = SASS_T / 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic mid_o,
    output logic end_o
);
    localparam int CW = $clog2(t);
    logic [CW-1:0] cnt_q, cnt_d;
    assign mid_o = cnt_q == CW'(mid_at);
    assign end_o = cnt_q == CW'(t - 1);
    always_comb cnt_d = (clr_i || end_o) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/sass_r.sv
// sass_r: SASS serial receiver (idle high, start low, LSB first, stop high)
//   clk, rst : clock, synchronous active-high reset
//   bus      : sass_r_if slave (s in; data, valid, busy, err out)
// Define SASS_R_MAJORITY_EN to take each bit as the 2-of-3 majority around
// the bit centre; decisions then land one cycle later.
module sass_r import sass_pkg::*; #(
    parameter int frame_l = SASS_FRAME_L,
    parameter int t = SASS_T
) (
    input  logic clk,
    input  logic rst,
    sass_r_if.slave bus
);
`ifdef SASS_R_MAJORITY_EN
    localparam int MID = t / 2 + 1;
`else
    localparam int MID = t / 2;
`endif
    localparam int IW = frame_l > 1 ? $clog2(frame_l) : 1;
    sass_state_e state_q, state_d;
    logic s_meta_q, s_sync_q;
    logic [IW-1:0] idx_q, idx_d;
    logic [frame_l-1:0] shift_q, shift_d, data_q, data_d;
    logic valid_q, valid_d, err_q, err_d;
    logic mid, bit_end, smp;
`ifdef SASS_R_MAJORITY_EN
    // hist_q[1] / hist_q[0] are s_sync two / one cycles back, so at the
    // decision cycle they line up with cnt = t/2-1 and t/2
    logic [1:0] hist_q;
    always_ff @(posedge clk) hist_q <= rst ? 2'b11 : {hist_q[0], s_sync_q};
    assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & s_sync_q) | (hist_q[0] & s_sync_q);
`else
    assign smp = s_sync_q;
`endif
    sass_bit_timer #(.t(t), .mid_at(MID)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr_i(state_q == IDLE || state_q == WAIT_IDLE),
        .mid_o(mid),
        .end_o(bit_end)
    );
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        shift_d = shift_q;
        data_d = data_q;
        valid_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: state_d = s_sync_q ? IDLE : START;
            START: begin
                if (mid && smp) state_d = IDLE;
                else if (bit_end) begin
                    state_d = DATA;
                    idx_d = '0;
                end
            end
            DATA: begin
                if (mid) shift_d[idx_q] = smp;
                if (bit_end) begin
                    if (idx_q == IW'(frame_l - 1)) state_d = STOP;
                    else idx_d = idx_q + IW'(1);
                end
            end
            STOP: begin
                // leave at the stop midpoint so a back-to-back start is caught
                if (mid) begin
                    state_d = smp ? IDLE : WAIT_IDLE;
                    data_d = smp ? shift_q : data_q;
                    valid_d = smp;
                    err_d = !smp;
                end
            end
            WAIT_IDLE: state_d = s_sync_q ? IDLE : WAIT_IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_meta_q <= 1'b1;
            s_sync_q <= 1'b1;
            idx_q <= '0;
            shift_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_meta_q <= bus.s;
            s_sync_q <= s_meta_q;
            idx_q <= idx_d;
            shift_q <= shift_d;
            data_q <= data_d;
            valid_q <= valid_d;
            err_q <= err_d;
        end
    end
    assign bus.data = data_q;
    assign bus.valid = valid_q;
    assign bus.err = err_q;
    assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_sass_r.sv
// tb_sass_r: randomized and directed checks of sass_r against a frame-level model
module tb_sass_r;
    import sass_pkg::*;
    localparam int FL = SASS_FRAME_L;
    localparam int T = SASS_T;
`ifdef SASS_R_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sass_r_if #(.frame_l(FL)) bus ();
    sass_r #(.frame_l(FL), .t(T)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0, failures = 0;
    int n_valid = 0, n_err = 0, n_both = 0, n_long = 0, n_unstable = 0;
    int lat = -1, busy_miss = 0;
    longint t_start = 0;
    bit mark_start = 0;
    logic [FL-1:0] got_q[$];
    logic [FL-1:0] exp_q[$];
    logic [FL-1:0] prev_data = '0;
    logic prev_valid = 1'b0, prev_err = 1'b0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.valid) begin
            n_valid++;
            got_q.push_back(bus.data);
            lat = int'(($time - 5 - t_start) / 10);
        end
        if (bus.err) n_err++;
        if (bus.valid && bus.err) n_both++;
        if ((bus.valid && prev_valid) || (bus.err && prev_err)) n_long++;
        if (!rst && !bus.valid && bus.data !== prev_data) n_unstable++;
        prev_data = bus.data;
        prev_valid = bus.valid;
        prev_err = bus.err;
    end
    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (mark_start) begin
                t_start = $time;
                mark_start = 0;
            end
            #1 bus.s = v;
        end
    endtask
    // one bit time; optional one-cycle inversion on the cycle the receiver samples
    task automatic send_bit(input logic v, input bit glitch);
        drive(v, T / 2);
        if (!bus.busy) busy_miss++;
        if (glitch) begin
            drive(v, 1);
            drive(~v, 1);
            drive(v, T - T / 2 - 2);
        end else drive(v, T - T / 2);
    endtask
    task automatic send_frame(input logic [FL-1:0] d, input logic stop, input bit glitch);
        mark_start = 1;
        send_bit(1'b0, 0);
        for (int i = 0; i < FL; i++) send_bit(d[i], glitch);
        send_bit(stop, 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int v0, e0, q0, expl, exp_err, gap;
        logic [FL-1:0] d;
        logic stop;
        bus.s = 1'b1;
        drive(1'b1, 5);
        check("rst_data", bus.data, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        drive(1'b1, 5);
        check("idle_busy", bus.busy, 0);
        // single frame 0x87
        v0 = n_valid; e0 = n_err; busy_miss = 0;
        send_frame(8'h87, 1'b1, 0);
        drive(1'b1, T);
        expl = (FL + 1) * T + T / 2 + 3 + MAJ;
        check("f87_valid", n_valid - v0, 1);
        check("f87_data", bus.data, 8'h87);
        check("f87_err", n_err - e0, 0);
        check("f87_busy", busy_miss, 0);
        check("f87_latency", (lat >= expl - 1 && lat <= expl + 1) ? expl : lat, expl);
        check("f87_idle", bus.busy, 0);
        // back-to-back frames
        v0 = n_valid; q0 = got_q.size();
        send_frame(8'd135, 1'b1, 0);
        send_frame(8'd95, 1'b1, 0);
        drive(1'b1, T);
        check("b2b_valid", n_valid - v0, 2);
        check("b2b_first", got_q[q0], 8'h87);
        check("b2b_second", got_q[q0 + 1], 8'h5F);
        check("b2b_data", bus.data, 8'h5F);
        // false start
        v0 = n_valid; e0 = n_err;
        drive(1'b0, 20);
        check("fs_busy", bus.busy, 1);
        drive(1'b1, 2 * T);
        check("fs_idle", bus.busy, 0);
        check("fs_valid", n_valid - v0, 0);
        check("fs_err", n_err - e0, 0);
        // framing error
        v0 = n_valid; e0 = n_err;
        send_frame(8'hA5, 1'b0, 0);
        drive(1'b0, T);
        check("fe_err", n_err - e0, 1);
        check("fe_valid", n_valid - v0, 0);
        check("fe_data", bus.data, 8'h5F);
        check("fe_busy", bus.busy, 1);
        drive(1'b1, 10);
        check("fe_recover", bus.busy, 0);
        // reset mid-frame at bit 4
        drive(1'b1, T);
        v0 = n_valid; e0 = n_err;
        d = 8'hE9;
        mark_start = 1;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 0);
        drive(d[4], T / 2);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.s = 1'b1;
        drive(1'b1, 2);
        rst = 1'b0;
        check("ab_busy", bus.busy, 0);
        check("ab_data", bus.data, 0);
        drive(1'b1, 2 * T);
        check("ab_valid", n_valid - v0, 0);
        check("ab_err", n_err - e0, 0);
        send_frame(8'h3C, 1'b1, 0);
        drive(1'b1, T);
        check("ab_next_valid", n_valid - v0, 1);
        check("ab_next_data", bus.data, 8'h3C);
        // midpoint glitches
        v0 = n_valid;
        send_frame(8'h87, 1'b1, 1);
        drive(1'b1, T);
        check("gl_valid", n_valid - v0, 1);
        check("gl_data", bus.data, MAJ ? 8'h87 : 8'h78);
        // random frames against the frame-level model
        v0 = n_valid; e0 = n_err; q0 = got_q.size(); exp_err = 0;
        repeat (12) begin
            d = FL'($urandom);
            stop = $urandom_range(0, 3) != 0;
            send_frame(d, stop, 0);
            if (stop) exp_q.push_back(d);
            else exp_err++;
            gap = stop ? $urandom_range(0, T / 2) : $urandom_range(4, T);
            if (gap > 0) drive(1'b1, gap);
        end
        drive(1'b1, T);
        check("rnd_valid", n_valid - v0, exp_q.size());
        check("rnd_err", n_err - e0, exp_err);
        for (int i = 0; i < exp_q.size(); i++) check("rnd_data", got_q[q0 + i], exp_q[i]);
        check("valid_err_same", n_both, 0);
        check("pulse_width", n_long, 0);
        check("data_stable", n_unstable, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sass_r.md
SASS_R -- requirements
Module: sass_r

Line format (shared with the SASS transmitter): idle high; start bit low for t cycles; frame_l data bits LSB first, t cycles each; stop bit high for t cycles.

Interface
REQ-001 SHALL have parameter frame_l, default 8, data bits per frame.
REQ-002 SHALL have parameter t, default 100, clock cycles per bit; legal range t >= 4.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port s  input  1  serial line, asynchronous to clk.
REQ-006 SHALL have port data  output  frame_l  last correctly received frame.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when data updates.
REQ-008 SHALL have port busy  output  1  high while a frame is being received.
REQ-009 SHALL have port err  output  1  one-cycle pulse on framing error (stop bit low).

Function
REQ-010 SHALL pass s through a 2-flop synchronizer (s_sync); the synchronizer resets to 1.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE with a bit counter cnt (0..t-1) and bit index idx (0..frame_l-1).
- IDLE: s_sync==0 -> START, cnt=0.
- START: at cnt==t/2, sampled 1 -> IDLE (glitch; no valid, no err); at cnt==t-1 -> DATA, idx=0.
- DATA: at cnt==t/2, shift the sample into the shift register at bit idx; at cnt==t-1, idx+1; after bit frame_l-1 -> STOP.
- STOP: at cnt==t/2, sample 1 -> data<=shift reg, valid=1, IDLE; sample 0 -> err=1, WAIT_IDLE; data unchanged.
- WAIT_IDLE: s_sync==1 -> IDLE.
REQ-012 SHALL return to IDLE at the stop-bit midpoint so that a back-to-back start bit is detected with no lost frame.
REQ-013 SHALL drive busy = (state != IDLE), combinationally from state.
REQ-014 SHALL never assert valid and err in the same cycle; each is high for exactly one clk cycle per event.
REQ-015 SHALL hold data stable between valid pulses.
REQ-016 SHALL assert valid (frame_l+1)*t + t/2 + 3 cycles (±1) after the falling edge of s at the start bit.
REQ-017 SHALL use counter widths of $clog2(t) for cnt and $clog2(frame_l) for idx, with no wrap beyond t-1 or frame_l-1.

Reset
REQ-018 SHALL, while rst=1, set state=IDLE, cnt=0, idx=0, shift reg=0, data=0, valid=0, err=0, busy=0, and synchronizer flops=1.
REQ-019 SHALL abort a frame in progress when rst asserts mid-frame: no valid and no err for that frame; reception restarts on the next falling edge after rst deasserts.

Configuration
REQ-020 SHALL support macro SASS_R_MAJORITY_EN: when defined, each bit value is the 2-of-3 majority of s_sync at cnt==t/2-1, t/2 and t/2+1, and decisions take effect at cnt==t/2+1, so every event shifts one cycle later. When undefined, a single sample at cnt==t/2 is used.

Structure
REQ-021 SHALL take the state enum and the default constants (SASS_FRAME_L=8, SASS_T=100) from shared package sass_pkg, which the transmitter also uses.
REQ-022 SHALL place the cnt logic in sub-module sass_bit_timer (inputs clk, rst, clr; outputs mid, end), instantiated once.

Verification
REQ-023 SHALL cover: frame_l=8, t=100; line driven with 8'd135 (0x87) -> one valid pulse, data=8'h87, err never asserted, busy high for the whole frame.
REQ-024 SHALL cover: 8'd95 sent immediately after 8'd135, with a stop bit of exactly t cycles -> two valid pulses, data=8'h87 then 8'h5F.
REQ-025 SHALL cover: s low for 20 cycles, then high -> busy pulses, state returns to IDLE, no valid, no err.
REQ-026 SHALL cover: frame 8'hA5 with the stop bit forced low -> err pulses once, data keeps its previous value, busy stays high until s returns high.
REQ-027 SHALL cover: rst pulsed at bit 4 of a frame, then 8'h3C sent -> no output for the aborted frame, then valid with data=8'h3C.
REQ-028 SHALL cover, with SASS_R_MAJORITY_EN defined: one-cycle inverted glitch at each bit midpoint of 8'h87 -> data=8'h87; without the macro, the same stimulus yields corrupted data.
